sram_rec_ctrl: RTL and testbench
================================

Name: sram_rec_ctrl

Overview:
- Record/playback sequencer sitting directly upstream of the SRAM codec stage in the audio recorder.
- Record path: accepts 16-bit samples from the audio ADC side and issues SRAM write cycles at incrementing addresses.
- Playback path: on DAC sample requests, issues SRAM read cycles and returns the words in order.
- Drives the codec stage's write/read/on/addrIn controls. Data nets are split into separate out/in/enable ports; the top-level ties them onto the bidirectional dataStream.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, sample/word width.
- WR_HOLD, 2, cycles write and write data are held per SRAM write (min 2).
- RD_LAT, 3, cycles from read assertion to sram_din capture (min 2).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_record  in  1  one-cycle pulse: start a new recording.
- cmd_play  in  1  one-cycle pulse: start playback from address 0.
- cmd_pause  in  1  one-cycle pulse: toggle pause in the current mode.
- cmd_stop  in  1  one-cycle pulse: return to idle.
- adc_valid  in  1  one-cycle strobe: adc_data holds a new sample.
- adc_data  in  DATA_W  record sample.
- dac_req  in  1  one-cycle strobe: DAC wants the next sample.
- dac_data  out  DATA_W  playback sample, held until the next update.
- dac_valid  out  1  one-cycle pulse when dac_data updates.
- play_done  out  1  one-cycle pulse when playback hits the end of the recording.
- write  out  1  to codec stage: write cycle.
- read  out  1  to codec stage: read cycle.
- on  out  1  to codec stage: chip enable request.
- addr  out  ADDR_W  to codec stage addrIn.
- sram_dout  out  DATA_W  write data toward dataStream.
- sram_dout_en  out  1  drive enable for sram_dout (equals write).
- sram_din  in  DATA_W  read data from dataStream.
- rec_len  out  ADDR_W+1  number of words in the stored recording.
- full  out  1  sticky: recording stopped at memory end.
- overrun  out  1  sticky: a sample or request arrived while busy and was dropped.
- mode  out  3  state encoding for LEDs/7-seg.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: mode=IDLE, all outputs 0, including addr, rec_len, dac_data, full, overrun.
- All outputs are registered.
- States: IDLE=0, REC_WAIT=1, REC_WR=2, REC_PAUSE=3, PLAY_WAIT=4, PLAY_RD=5, PLAY_PAUSE=6.
- on=1 in every state except IDLE.
- Command priority when several pulse together: stop > pause > record > play.
- stop: any state -> IDLE next cycle. Clears write/read at once. An in-flight write is not counted in rec_len. An in-flight read produces no dac_valid.
- IDLE + cmd_record -> REC_WAIT. addr=0, rec_len=0, full=0, overrun=0.
- IDLE + cmd_play:
  - If rec_len=0: play_done pulse, stay IDLE.
  - Otherwise -> PLAY_WAIT with addr=0 and overrun cleared.
- record/play commands outside IDLE are ignored.
- REC_WAIT + adc_valid -> REC_WR: latch adc_data into sram_dout; write=1 and sram_dout_en=1 for exactly WR_HOLD cycles; addr stable throughout.
- End of REC_WR: write=0, rec_len=addr+1.
  - If addr = 2^ADDR_W-1: full=1 -> IDLE.
  - Otherwise addr+1 -> REC_WAIT.
- adc_valid during REC_WR or REC_PAUSE: sample dropped. In REC_WR it also sets overrun; in REC_PAUSE it does not.
- PLAY_WAIT + dac_req:
  - If addr = rec_len: play_done pulse -> IDLE.
  - Otherwise -> PLAY_RD with read=1.
- PLAY_RD: on the RD_LAT-th cycle after read asserted, capture sram_din into dac_data and pulse dac_valid. Then read=0, addr+1 -> PLAY_WAIT.
- dac_req during PLAY_RD: dropped, sets overrun.
- write and read are never 1 together. Both are 0 for at least one cycle between consecutive accesses.
- pause:
  - REC_WAIT <-> REC_PAUSE and PLAY_WAIT <-> PLAY_PAUSE toggle immediately.
  - In REC_WR or PLAY_RD, pause is latched pending and applied when the access ends (next state becomes the PAUSE state).
  - A second pause pulse while pending cancels it.
- Paused states keep addr and on=1, and issue no accesses.
- Reset mid-access: outputs clear asynchronously; the recording is lost (rec_len=0).

Test Plan:
- Reset then record 4 samples 0x1111,0x2222,0x3333,0x4444 -> write pulses of 2 cycles each at addr 0..3, sram_dout matches each sample, rec_len=4, mode returns to REC_WAIT.
- After the above: stop, play, 5 dac_req with sram_din modelled as memory -> dac_valid 4 times with dac_data 0x1111..0x4444 each 3 cycles after read; the 5th request gives play_done and mode=IDLE.
- adc_valid again 1 cycle into REC_WR -> sample dropped, overrun=1, rec_len increments by 1 only.
- cmd_pause during REC_WR -> write completes, then mode=REC_PAUSE; adc_valid ignored; second pause -> REC_WAIT.
- Preload addr near the end with ADDR_W=4 build, record 16 samples -> full=1, rec_len=16, mode=IDLE; 17th adc_valid ignored.
- Same-cycle cmd_stop+cmd_record in REC_WR -> IDLE, write=0 next cycle; rst_n low mid-PLAY_RD -> all outputs 0 immediately, no dac_valid.

Source files
------------

// File: rtl/sram_rec_ctrl.sv
// Record/playback sequencer driving the SRAM codec stage: timed write cycles at incrementing
// addresses on ADC samples, timed read cycles on DAC requests, with pause/stop control.
module sram_rec_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int WR_HOLD = 2,
  parameter int RD_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_record,
  input  logic              cmd_play,
  input  logic              cmd_pause,
  input  logic              cmd_stop,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              play_done,
  output logic              write,
  output logic              read,
  output logic              on,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic [ADDR_W:0]   rec_len,
  output logic              full,
  output logic              overrun,
  output logic [2:0]        mode
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC_WAIT   = 3'd1,
    ST_REC_WR     = 3'd2,
    ST_REC_PAUSE  = 3'd3,
    ST_PLAY_WAIT  = 3'd4,
    ST_PLAY_RD    = 3'd5,
    ST_PLAY_PAUSE = 3'd6
  } state_t;

  localparam int MAX_LAT = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0]  WR_LAST  = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pause_pend;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_rec_len;
  logic [DATA_W-1:0]   r_sram_dout;
  logic [DATA_W-1:0]   r_dac_data;
  logic                r_dac_valid;
  logic                r_play_done;
  logic                r_write;
  logic                r_read;
  logic                r_on;
  logic                r_full;
  logic                r_overrun;

  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_pend_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W:0]     w_rec_len_nxt;
  logic [DATA_W-1:0]   w_sram_dout_nxt;
  logic [DATA_W-1:0]   w_dac_data_nxt;
  logic                w_dac_valid_nxt;
  logic                w_play_done_nxt;
  logic                w_full_nxt;
  logic                w_overrun_nxt;

  logic w_wr_end;
  logic w_rd_end;
  logic w_pend_eff;
  logic w_addr_last;
  logic w_play_end;

  assign w_wr_end    = (r_state == ST_REC_WR)  && (r_cnt == WR_LAST);
  assign w_rd_end    = (r_state == ST_PLAY_RD) && (r_cnt == RD_LAST);
  // A pause pulse on the final access cycle still counts (or cancels a pending one).
  assign w_pend_eff  = r_pause_pend ^ cmd_pause;
  assign w_addr_last = &r_addr;
  assign w_play_end  = ({1'b0, r_addr} == r_rec_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cmd_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_record)                        w_state_nxt = ST_REC_WAIT;
          else if (cmd_play && (r_rec_len != '0)) w_state_nxt = ST_PLAY_WAIT;
        end
        ST_REC_WAIT: begin
          if (cmd_pause)      w_state_nxt = ST_REC_PAUSE;
          else if (adc_valid) w_state_nxt = ST_REC_WR;
        end
        ST_REC_WR: begin
          if (w_wr_end) begin
            if (w_addr_last)     w_state_nxt = ST_IDLE;
            else if (w_pend_eff) w_state_nxt = ST_REC_PAUSE;
            else                 w_state_nxt = ST_REC_WAIT;
          end
        end
        ST_REC_PAUSE: begin
          if (cmd_pause) w_state_nxt = ST_REC_WAIT;
        end
        ST_PLAY_WAIT: begin
          if (cmd_pause)    w_state_nxt = ST_PLAY_PAUSE;
          else if (dac_req) w_state_nxt = w_play_end ? ST_IDLE : ST_PLAY_RD;
        end
        ST_PLAY_RD: begin
          if (w_rd_end) w_state_nxt = w_pend_eff ? ST_PLAY_PAUSE : ST_PLAY_WAIT;
        end
        ST_PLAY_PAUSE: begin
          if (cmd_pause) w_state_nxt = ST_PLAY_WAIT;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt       = '0;
    w_pend_nxt      = 1'b0;
    w_addr_nxt      = r_addr;
    w_rec_len_nxt   = r_rec_len;
    w_sram_dout_nxt = r_sram_dout;
    w_dac_data_nxt  = r_dac_data;
    w_dac_valid_nxt = 1'b0;
    w_play_done_nxt = 1'b0;
    w_full_nxt      = r_full;
    w_overrun_nxt   = r_overrun;
    if (!cmd_stop) begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_record) begin
            w_addr_nxt    = '0;
            w_rec_len_nxt = '0;
            w_full_nxt    = 1'b0;
            w_overrun_nxt = 1'b0;
          end else if (cmd_play) begin
            if (r_rec_len == '0) begin
              w_play_done_nxt = 1'b1;
            end else begin
              w_addr_nxt    = '0;
              w_overrun_nxt = 1'b0;
            end
          end
        end
        ST_REC_WAIT: begin
          if (!cmd_pause && adc_valid) w_sram_dout_nxt = adc_data;
        end
        ST_REC_WR: begin
          if (adc_valid) w_overrun_nxt = 1'b1;
          if (w_wr_end) begin
            w_rec_len_nxt = {1'b0, r_addr} + LEN_ONE;
            if (w_addr_last) w_full_nxt = 1'b1;
            else             w_addr_nxt = r_addr + ADDR_ONE;
          end else begin
            w_cnt_nxt  = r_cnt + CNT_ONE;
            w_pend_nxt = w_pend_eff;
          end
        end
        ST_PLAY_WAIT: begin
          if (!cmd_pause && dac_req && w_play_end) w_play_done_nxt = 1'b1;
        end
        ST_PLAY_RD: begin
          if (dac_req) w_overrun_nxt = 1'b1;
          if (w_rd_end) begin
            w_dac_data_nxt  = sram_din;
            w_dac_valid_nxt = 1'b1;
            w_addr_nxt      = r_addr + ADDR_ONE;
          end else begin
            w_cnt_nxt  = r_cnt + CNT_ONE;
            w_pend_nxt = w_pend_eff;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes follow the next state, so write/read drop on the same edge that ends the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_pause_pend <= 1'b0;
      r_addr       <= '0;
      r_rec_len    <= '0;
      r_sram_dout  <= '0;
      r_dac_data   <= '0;
      r_dac_valid  <= 1'b0;
      r_play_done  <= 1'b0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_on         <= 1'b0;
      r_full       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_pause_pend <= w_pend_nxt;
      r_addr       <= w_addr_nxt;
      r_rec_len    <= w_rec_len_nxt;
      r_sram_dout  <= w_sram_dout_nxt;
      r_dac_data   <= w_dac_data_nxt;
      r_dac_valid  <= w_dac_valid_nxt;
      r_play_done  <= w_play_done_nxt;
      r_write      <= (w_state_nxt == ST_REC_WR);
      r_read       <= (w_state_nxt == ST_PLAY_RD);
      r_on         <= (w_state_nxt != ST_IDLE);
      r_full       <= w_full_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign mode         = r_state;
  assign addr         = r_addr;
  assign rec_len      = r_rec_len;
  assign sram_dout    = r_sram_dout;
  assign sram_dout_en = r_write;
  assign write        = r_write;
  assign read         = r_read;
  assign on           = r_on;
  assign dac_data     = r_dac_data;
  assign dac_valid    = r_dac_valid;
  assign play_done    = r_play_done;
  assign full         = r_full;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sram_rec_ctrl.sv
// Directed bench for sram_rec_ctrl built with a 4-bit address so memory-end handling is reachable.
module tb_sram_rec_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_record, cmd_play, cmd_pause, cmd_stop;
  logic          adc_valid, dac_req;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] dac_data;
  logic          dac_valid, play_done, write, read, on;
  logic [AW-1:0] addr;
  logic [DW-1:0] sram_dout, sram_din;
  logic          sram_dout_en;
  logic [AW:0]   rec_len;
  logic          full, overrun;
  logic [2:0]    mode;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem  [0:15];
  logic [DW-1:0] samp [0:3];

  always #5 clk = ~clk;

  always @(posedge clk) if (write) mem[addr] <= sram_dout;
  assign sram_din = mem[addr];

  sram_rec_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WR_HOLD(2), .RD_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
    .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req),
    .dac_data(dac_data), .dac_valid(dac_valid), .play_done(play_done),
    .write(write), .read(read), .on(on), .addr(addr),
    .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din),
    .rec_len(rec_len), .full(full), .overrun(overrun), .mode(mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    samp[0] = 16'h1111; samp[1] = 16'h2222; samp[2] = 16'h3333; samp[3] = 16'h4444;
    rst_n = 1'b0;
    cmd_record = 1'b0; cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
    adc_valid = 1'b0; dac_req = 1'b0; adc_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);       chk("rst_on", on, 0);
    chk("rst_write", write, 0);     chk("rst_read", read, 0);
    chk("rst_addr", addr, 0);       chk("rst_rec_len", rec_len, 0);
    chk("rst_dac_data", dac_data, 0); chk("rst_full", full, 0);
    chk("rst_overrun", overrun, 0); chk("rst_dout_en", sram_dout_en, 0);
    rst_n = 1'b1;
    tick();

    // Record four samples
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    chk("rec_mode", mode, 1); chk("rec_on", on, 1); chk("rec_addr0", addr, 0);
    for (int i = 0; i < 4; i++) begin
      adc_data = samp[i]; adc_valid = 1'b1; tick(); adc_valid = 1'b0;
      chk("wr_start", write, 1);  chk("wr_en", sram_dout_en, 1);
      chk("wr_dout", sram_dout, samp[i]); chk("wr_addr", addr, i); chk("wr_mode", mode, 2);
      tick();
      chk("wr_hold", write, 1); chk("wr_addr_hold", addr, i);
      tick();
      chk("wr_off", write, 0); chk("wr_rec_len", rec_len, i + 1); chk("wr_back_wait", mode, 1);
    end

    // Stop then play back
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("stop_mode", mode, 0); chk("stop_on", on, 0); chk("stop_rec_len", rec_len, 4);
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    chk("play_mode", mode, 4); chk("play_addr0", addr, 0);
    for (int i = 0; i < 4; i++) begin
      dac_req = 1'b1; tick(); dac_req = 1'b0;
      chk("rd_start", read, 1); chk("rd_no_write", write, 0); chk("rd_addr", addr, i);
      tick(); chk("rd_lat1", dac_valid, 0);
      tick(); chk("rd_lat2", dac_valid, 0);
      tick();
      chk("rd_valid", dac_valid, 1); chk("rd_data", dac_data, samp[i]);
      chk("rd_off", read, 0); chk("rd_addr_inc", addr, i + 1);
      tick();
      chk("rd_valid_pulse", dac_valid, 0); chk("rd_data_hold", dac_data, samp[i]);
    end
    dac_req = 1'b1; tick(); dac_req = 1'b0;
    chk("play_done", play_done, 1); chk("play_end_mode", mode, 0);
    tick(); chk("play_done_pulse", play_done, 0);

    // Pause latched during a write, samples ignored while paused
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    chk("rerec_len", rec_len, 0);
    adc_data = 16'hCCCC; adc_valid = 1'b1; tick(); adc_valid = 1'b0;
    cmd_pause = 1'b1; tick(); cmd_pause = 1'b0;
    chk("pend_mode", mode, 2); chk("pend_write", write, 1);
    tick();
    chk("pause_mode", mode, 3); chk("pause_write", write, 0);
    chk("pause_rec_len", rec_len, 1); chk("pause_addr", addr, 1);
    adc_data = 16'hDDDD; adc_valid = 1'b1; tick(); adc_valid = 1'b0;
    chk("pause_adc_mode", mode, 3); chk("pause_adc_write", write, 0);
    chk("pause_no_ovr", overrun, 0); chk("pause_adc_addr", addr, 1);
    tick(); chk("pause_len_hold", rec_len, 1);
    cmd_pause = 1'b1; tick(); cmd_pause = 1'b0;
    chk("unpause_mode", mode, 1);

    // Sample arriving mid-write is dropped and flagged
    adc_data = 16'hAAAA; adc_valid = 1'b1; tick();
    adc_data = 16'hBBBB; tick(); adc_valid = 1'b0;
    chk("ovr_flag", overrun, 1); chk("ovr_dout", sram_dout, 16'hAAAA);
    tick();
    chk("ovr_rec_len", rec_len, 2); chk("ovr_mode", mode, 1); chk("ovr_addr", addr, 2);

    // Second pause on the final write cycle cancels the pending one
    adc_data = 16'hEEEE; adc_valid = 1'b1; tick(); adc_valid = 1'b0;
    cmd_pause = 1'b1; tick(); tick(); cmd_pause = 1'b0;
    chk("cancel_mode", mode, 1); chk("cancel_rec_len", rec_len, 3);

    // Stop and record together mid-write
    adc_data = 16'hFFFF; adc_valid = 1'b1; tick(); adc_valid = 1'b0;
    chk("sr_write", write, 1);
    cmd_stop = 1'b1; cmd_record = 1'b1; tick(); cmd_stop = 1'b0; cmd_record = 1'b0;
    chk("sr_mode", mode, 0); chk("sr_write_off", write, 0);
    chk("sr_on", on, 0); chk("sr_rec_len", rec_len, 3);
    tick(); chk("sr_stay_idle", mode, 0);

    // Fill the whole memory
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    for (int i = 0; i < 16; i++) begin
      adc_data = 16'h5000 + 16'(i); adc_valid = 1'b1; tick(); adc_valid = 1'b0;
      chk("full_addr", addr, i); chk("full_dout", sram_dout, 16'h5000 + i);
      tick(); tick();
      chk("full_flag", full, (i == 15) ? 1 : 0);
      chk("full_mode", mode, (i == 15) ? 0 : 1);
      chk("full_rec_len", rec_len, i + 1);
    end
    adc_valid = 1'b1; tick(); adc_valid = 1'b0;
    chk("full_17_mode", mode, 0); chk("full_17_write", write, 0);
    chk("full_17_len", rec_len, 16); chk("full_17_flag", full, 1);

    // Reset in the middle of a read
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    chk("rr_mode", mode, 4);
    dac_req = 1'b1; tick(); dac_req = 1'b0;
    chk("rr_read", read, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rr_read_clr", read, 0); chk("rr_mode_clr", mode, 0); chk("rr_on_clr", on, 0);
    chk("rr_len_clr", rec_len, 0); chk("rr_full_clr", full, 0);
    chk("rr_addr_clr", addr, 0); chk("rr_data_clr", dac_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rr_no_valid", dac_valid, 0);
    end
    rst_n = 1'b1;
    tick();
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    chk("empty_play_done", play_done, 1); chk("empty_play_mode", mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
